// File: rtl/mem_access_unit.sv
// Load/store unit between a core request port and a word-wide data memory.
// Handles byte/half/word accesses, sign extension and read-modify-write sub-word stores.
module mem_access_unit #(
  parameter int MEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [1:0]  SZ_ILL    = 2'b11;
  localparam logic [29:0] DEPTH_IDX = 30'(MEM_DEPTH);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdword;
  logic        r_err;

  logic        w_accept;
  logic        w_size_bad;
  logic        w_misalign;
  logic        w_oob;
  logic        w_req_err;
  logic [31:0] w_index;
  logic [7:0]  w_byte_sel;
  logic [15:0] w_half_sel;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  // Request legality is judged on the live request so the error path needs no extra state.
  assign w_size_bad = (req_size == SZ_ILL);
  assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_oob      = (req_addr[31:2] >= DEPTH_IDX);
  assign w_req_err  = w_size_bad || w_misalign || w_oob;

  assign w_index = {2'b00, r_addr[31:2]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_state_next = S_RESP;
          end else if (req_we && (req_size == SZ_WORD)) begin
            w_state_next = S_WRITE;
          end else begin
            w_state_next = S_READ;
          end
        end
      end
      S_READ:  w_state_next = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request capture and read-word register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_rdword <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
      end
      if (r_state == S_READ) begin
        r_rdword <= mem_rd;
      end
    end
  end

  // Load lane extraction and extension
  assign w_byte_sel = r_rdword[{r_addr[1:0], 3'b000} +: 8];
  assign w_half_sel = r_rdword[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = r_rdword;
    case (r_size)
      SZ_BYTE: w_load_data = {{24{r_signed & w_byte_sel[7]}}, w_byte_sel};
      SZ_HALF: w_load_data = {{16{r_signed & w_half_sel[15]}}, w_half_sel};
      default: w_load_data = r_rdword;
    endcase
  end

  // Sub-word store merge: each byte lane takes new data only if the access covers it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       w_lane_hit;
      logic [7:0] w_lane_src;

      assign w_lane_hit = ((r_size == SZ_BYTE) && (r_addr[1:0] == 2'(gi))) ||
                          ((r_size == SZ_HALF) && (r_addr[1] == 1'(gi / 2)));
      assign w_lane_src = (r_size == SZ_BYTE) ? r_wdata[7:0] : r_wdata[8*(gi%2) +: 8];
      assign w_merged[8*gi +: 8] = w_lane_hit ? w_lane_src : r_rdword[8*gi +: 8];
    end
  endgenerate

  // Output logic
  always_comb begin
    mem_a     = 32'h0;
    mem_wd    = 32'h0;
    mem_we    = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    rsp_err   = 1'b0;
    case (r_state)
      S_READ: begin
        mem_a = w_index;
      end
      S_WRITE: begin
        mem_a  = w_index;
        mem_wd = (r_size == SZ_WORD) ? r_wdata : w_merged;
        mem_we = 1'b1;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_err || r_we) ? 32'h0 : w_load_data;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model on the memory port.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_DEPTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd)
  );

  logic [31:0] tb_mem [0:63] = '{default: 32'h0};
  assign mem_rd = tb_mem[mem_a[5:0]];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_a[5:0]] <= mem_wd;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_wr, input logic [31:0] exp_a, input logic [31:0] exp_wd);
    int          lat;
    int          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    check_val({tag, " ready"}, 32'(req_ready), 32'd1);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    tick();
    // Scramble the request bus to prove the unit works from latched values.
    req_valid  = 1'b0;
    req_we     = ~we;
    req_size   = 2'b11;
    req_signed = ~sgn;
    req_addr   = 32'hFFFF_FFF3;
    req_wdata  = 32'hDEAD_BEEF;
    lat = 1;
    wr  = 0;
    a   = 32'h0;
    wd  = 32'h0;
    while (1) begin
      if (mem_we) begin
        wr++;
        a  = mem_a;
        wd = mem_wd;
      end
      if (rsp_valid || lat >= 10) break;
      tick();
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check_val({tag, " rdata"}, rd, exp_rdata);
    check_val({tag, " err"}, 32'(er), 32'(exp_err));
    check_val({tag, " writes"}, 32'(wr), 32'(exp_wr));
    if (exp_wr > 0) begin
      check_val({tag, " mem_a"}, a, exp_a);
      check_val({tag, " mem_wd"}, wd, exp_wd);
    end
    tick();
    check_val({tag, " pulse end"}, 32'(rsp_valid), 32'd0);
    check_val({tag, " rdata clr"}, rsp_rdata, 32'h0);
    check_val({tag, " idle"}, 32'(req_ready), 32'd1);
    $display("%s: lat=%0d rdata=0x%08h err=%0d writes=%0d", tag, lat, rd, er, wr);
  endtask

  initial begin
    int bad;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    tick();
    check_val("rst ready", 32'(req_ready), 32'd0);
    tick();
    check_val("rst ready2", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_val("post rst ready", 32'(req_ready), 32'd1);
    check_val("post rst rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("post rst rdata", rsp_rdata, 32'h0);
    check_val("post rst err", 32'(rsp_err), 32'd0);
    check_val("post rst mem_a", mem_a, 32'h0);
    check_val("post rst mem_wd", mem_wd, 32'h0);
    check_val("post rst mem_we", 32'(mem_we), 32'd0);
    $display("reset: ready=%0d", req_ready);

    //      tag          we    size   sgn   addr          wdata          lat rdata          err  wr a      wd
    run_req("sw 08",     1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h89AB_CDEF, 2, 32'h0,         1'b0, 1, 32'd2,  32'h89AB_CDEF);
    run_req("lb 0B",     1'b0, 2'b00, 1'b1, 32'h0000_000B, 32'h0,         2, 32'hFFFF_FF89, 1'b0, 0, 32'd0,  32'h0);
    run_req("lbu 0B",    1'b0, 2'b00, 1'b0, 32'h0000_000B, 32'h0,         2, 32'h0000_0089, 1'b0, 0, 32'd0,  32'h0);
    run_req("sh 0A",     1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h0000_1234, 3, 32'h0,         1'b0, 1, 32'd2,  32'h1234_CDEF);
    run_req("lhu 0A",    1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0,         2, 32'h0000_1234, 1'b0, 0, 32'd0,  32'h0);
    run_req("lh 08",     1'b0, 2'b01, 1'b1, 32'h0000_0008, 32'h0,         2, 32'hFFFF_CDEF, 1'b0, 0, 32'd0,  32'h0);
    run_req("lbu 09",    1'b0, 2'b00, 1'b0, 32'h0000_0009, 32'h0,         2, 32'h0000_00CD, 1'b0, 0, 32'd0,  32'h0);
    run_req("lb 08",     1'b0, 2'b00, 1'b1, 32'h0000_0008, 32'h0,         2, 32'hFFFF_FFEF, 1'b0, 0, 32'd0,  32'h0);
    run_req("lw 06",     1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         1, 32'h0,         1'b1, 0, 32'd0,  32'h0);
    run_req("sw 100",    1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1111_2222, 1, 32'h0,         1'b1, 0, 32'd0,  32'h0);
    run_req("size11",    1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         1, 32'h0,         1'b1, 0, 32'd0,  32'h0);
    run_req("sh 09",     1'b1, 2'b01, 1'b0, 32'h0000_0009, 32'h0000_AAAA, 1, 32'h0,         1'b1, 0, 32'd0,  32'h0);
    run_req("sw FC",     1'b1, 2'b10, 1'b0, 32'h0000_00FC, 32'hA5A5_0F0F, 2, 32'h0,         1'b0, 1, 32'd63, 32'hA5A5_0F0F);
    run_req("lw FC",     1'b0, 2'b10, 1'b0, 32'h0000_00FC, 32'h0,         2, 32'hA5A5_0F0F, 1'b0, 0, 32'd0,  32'h0);
    run_req("sb 0D",     1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'hFFFF_FF77, 3, 32'h0,         1'b0, 1, 32'd3,  32'h0000_7700);
    run_req("lw 0C",     1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,         2, 32'h0000_7700, 1'b0, 0, 32'd0,  32'h0);
    run_req("lb 0D",     1'b0, 2'b00, 1'b1, 32'h0000_000D, 32'h0,         2, 32'h0000_0077, 1'b0, 0, 32'd0,  32'h0);

    // Abort a sub-word store with reset while it is reading.
    check_val("abort ready", 32'(req_ready), 32'd1);
    req_we     = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0000_0008;
    req_wdata  = 32'h0000_0055;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    check_val("abort read mem_a", mem_a, 32'd2);
    check_val("abort read mem_we", 32'(mem_we), 32'd0);
    rst = 1'b1;
    tick();
    check_val("abort rst ready", 32'(req_ready), 32'd0);
    check_val("abort rst mem_we", 32'(mem_we), 32'd0);
    check_val("abort rst rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_we || rsp_valid) bad++;
      tick();
    end
    check_val("abort quiet", 32'(bad), 32'd0);
    $display("abort sb 08: stray events=%0d", bad);
    run_req("lw 08",     1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         2, 32'h1234_CDEF, 1'b0, 0, 32'd0,  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
